x_mod_stream: RTL and testbench

Streaming, parametrised residue engine: computes X mod MOD for an operand of arbitrary length delivered as CW-bit chunks over a valid/ready stream, one chunk per clock. It generalises the fixed-width combinational x_*_mod_* reducers. Operand length is decided at run time by in_last, bounded by MAX_CHUNKS. Chunk order is selectable (MSB-first or LSB-first). It sits between an operand source such as a DMA or shift buffer and any consumer of RW-bit residues.

---
 rtl/x_mod_stream.sv | 75 +++++++
 tb/tb_x_mod_stream.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/x_mod_stream.sv
// x_mod_stream: streaming residue X mod MOD over CW-bit chunks, MSB- or LSB-first
module x_mod_stream #(
  parameter int MOD        = 997,
  parameter int RW         = 10,
  parameter int CW         = 10,
  parameter int MAX_CHUNKS = 40,
  parameter int LSB_FIRST  = 0,
  localparam int NW        = $clog2(MAX_CHUNKS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_r,
  output logic          out_ovf,
  output logic [NW-1:0] out_cnt
);
  localparam int DW = CW > RW ? CW : RW;
  localparam int PW = 2 * RW + 1;
  function automatic longint chunk_weight();
    longint k = 1;
    for (int i = 0; i < CW; i++) k = (k * 2) % MOD;
    return k;
  endfunction
  localparam logic [RW-1:0] K     = RW'(chunk_weight());
  localparam logic [DW-1:0] MOD_D = DW'(MOD);
  localparam logic [PW-1:0] MOD_P = PW'(MOD);
  typedef enum logic {ACC, DONE} state_t;
  state_t st, st_nxt;
  logic [RW-1:0] acc, w, d;
  logic [NW-1:0] cnt, cnt_inc;
  logic [PW-1:0] sum, w_prod;
  logic ovf, fire, take, full;
  assign in_ready  = st == ACC;
  assign out_valid = st == DONE;
  assign out_r     = acc;
  assign out_cnt   = cnt;
  assign out_ovf   = ovf;
  assign fire      = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign full      = cnt_inc == NW'(MAX_CHUNKS);
  // chunk pre-reduced below MOD so every product fits in 2*RW bits plus a carry
  assign d         = RW'(DW'(in_data) % MOD_D);
  assign sum       = LSB_FIRST != 0 ? PW'(d) * PW'(w) + PW'(acc) : PW'(acc) * PW'(K) + PW'(d);
  assign w_prod    = PW'(w) * PW'(K);
  // next state: final or MAX_CHUNKS-th beat enters DONE, result handshake returns to ACC
  always_comb st_nxt = fire && (in_last || full) ? DONE : take ? ACC : st;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) st <= ACC;
    else st <= st_nxt;
  // residue, positional weight, beat count and overflow flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      w   <= RW'(1);
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      acc <= '0;
      w   <= RW'(1);
      cnt <= '0;
      ovf <= 1'b0;
    end else if (fire) begin
      acc <= RW'(sum % MOD_P);
      w   <= RW'(w_prod % MOD_P);
      cnt <= cnt_inc;
      ovf <= full && !in_last;
    end
endmodule

// File: tb/tb_x_mod_stream.sv
// tb_x_mod_stream: random and directed checks of both chunk orders against a big-integer model
module tb_x_mod_stream;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [9:0] in_data = '0;
  logic m_in_ready, l_in_ready, m_out_valid, l_out_valid, m_out_ovf, l_out_ovf;
  logic [9:0] m_out_r, l_out_r;
  logic [5:0] m_out_cnt, l_out_cnt;
  int n_chk = 0, n_pass = 0;
  bit [9:0] ch [40];
  int last_m, last_l, last_cnt, last_ovf;
  always #5 clk = ~clk;
  x_mod_stream #(.LSB_FIRST(0)) u_msb (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(m_out_valid), .out_ready(out_ready),
    .out_r(m_out_r), .out_ovf(m_out_ovf), .out_cnt(m_out_cnt));
  x_mod_stream #(.LSB_FIRST(1)) u_lsb (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_r(l_out_r), .out_ovf(l_out_ovf), .out_cnt(l_out_cnt));
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  function automatic logic [399:0] build(input int n, input bit lsb);
    logic [399:0] x = '0;
    for (int i = 0; i < n; i++) x[(lsb ? i : n - 1 - i) * 10 +: 10] = ch[i];
    return x;
  endfunction
  function automatic int ref_mod(input logic [399:0] x);
    int r = 0;
    for (int b = 399; b >= 0; b--) r = (r * 2 + int'(x[b])) % 997;
    return r;
  endfunction
  task automatic run_op(input int n, input bit use_last, input int hold);
    int i = 0, b = 0, em, el;
    bit go;
    em = ref_mod(build(n, 0));
    el = ref_mod(build(n, 1));
    while (i < n && b < 2000) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 3) != 0;
      in_data  = ch[i];
      in_last  = use_last && i == n - 1;
      go = in_valid && m_in_ready;
      @(posedge clk);
      if (go) i++;
      b++;
    end
    @(negedge clk);
    in_valid = hold > 0;
    in_data  = '0;
    in_last  = hold > 0;
    if (i < n) chk("op_timeout", i, n);
    chk("latency_msb", m_out_valid, 1);
    chk("latency_lsb", l_out_valid, 1);
    last_m = m_out_r;
    last_l = l_out_r;
    last_cnt = m_out_cnt;
    last_ovf = m_out_ovf;
    for (int k = 0; k < hold; k++) begin
      chk("bp_ready", m_in_ready, 0);
      chk("bp_r", m_out_r, em);
      chk("bp_cnt", m_out_cnt, n);
      @(posedge clk);
      @(negedge clk);
    end
    b = 0;
    go = 0;
    while (!go) begin
      chk("done_ready", m_in_ready, 0);
      chk("r_msb", m_out_r, em);
      chk("r_lsb", l_out_r, el);
      chk("cnt_msb", m_out_cnt, n);
      chk("cnt_lsb", l_out_cnt, n);
      chk("ovf_msb", m_out_ovf, !use_last);
      chk("ovf_lsb", l_out_ovf, !use_last);
      out_ready = hold > 0 || b >= 20 || $urandom_range(0, 1) == 1;
      go = out_ready;
      @(posedge clk);
      @(negedge clk);
      b++;
    end
    out_ready = 0;
    chk("ack_valid", m_out_valid, 0);
    chk("ack_ready", m_in_ready, 1);
  endtask
  task automatic fill(input int n, input int v);
    for (int i = 0; i < n; i++) ch[i] = 10'(v);
  endtask
  initial begin
    #2;
    chk("rst_ready", m_in_ready, 1);
    chk("rst_valid", m_out_valid, 0);
    chk("rst_r", m_out_r, 0);
    chk("rst_ovf", m_out_ovf, 0);
    chk("rst_cnt", m_out_cnt, 0);
    #20 rst_n = 1;
    fill(1, 1023);
    run_op(1, 1, 0);
    chk("single_1023", last_m, 26);
    chk("single_cnt", last_cnt, 1);
    ch[0] = 1; ch[1] = 0;
    run_op(2, 1, 0);
    chk("msb_1_0", last_m, 27);
    chk("lsb_1_0", last_l, 1);
    ch[0] = 5; ch[1] = 1;
    run_op(2, 1, 0);
    chk("msb_5_1", last_m, 136);
    chk("lsb_5_1", last_l, 32);
    fill(3, 1023);
    run_op(3, 1, 0);
    chk("msb_3x1023", last_m, 739);
    chk("lsb_3x1023", last_l, 739);
    fill(40, 1023);
    run_op(40, 0, 0);
    chk("ovf_flag", last_ovf, 1);
    chk("ovf_cnt", last_cnt, 40);
    chk("ovf_r", last_m, ref_mod({400{1'b1}}));
    run_op(40, 1, 0);
    chk("last_at_max_ovf", last_ovf, 0);
    fill(1, 1023);
    run_op(1, 1, 5);
    @(posedge clk);
    @(negedge clk);
    chk("pending_valid", m_out_valid, 1);
    chk("pending_r", m_out_r, 0);
    chk("pending_cnt", m_out_cnt, 1);
    in_valid = 0;
    in_last = 0;
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    in_valid = 1;
    in_data = 10'd1023;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_ready", m_in_ready, 1);
    chk("mid_rst_valid", m_out_valid, 0);
    chk("mid_rst_cnt", m_out_cnt, 0);
    chk("mid_rst_r", l_out_r, 0);
    @(negedge clk) rst_n = 1;
    fill(1, 1023);
    run_op(1, 1, 0);
    chk("post_rst_1023", last_m, 26);
    for (int op = 0; op < 1000; op++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        int s = $urandom_range(0, 3);
        ch[i] = s == 0 ? 10'd1023 : s == 1 ? 10'($urandom_range(997, 1023)) : 10'($urandom);
      end
      run_op(n, n < 40 || $urandom_range(0, 1) == 1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
